ps2_key_event_fifo: RTL and testbench

//  Consumes raw PS/2 bytes (received_data/received_data_en) from PS2_Controller and decodes

---
 rtl/ps2_key_event_fifo.sv | 138 +++++++++++++
 tb/tb_ps2_key_event_fifo.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/ps2_key_event_fifo.sv
// PS/2 key-event decoder feeding a first-word-fall-through event FIFO.
// Raw scan-code bytes are folded into one {ext, brk, code} word per key action.
// The CPU reads these words as a memory-mapped keyboard port.
module ps2_key_event_fifo #(
  parameter int DEPTH     = 16,
  parameter int CNT_W     = 5,
  parameter int PAUSE_LEN = 7
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rd_en,
  input  logic        ovf_clr,
  output logic [31:0] rd_data,
  output logic        empty,
  output logic        full,
  output logic        overflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW = $clog2(PAUSE_LEN + 1);

  typedef enum logic [2:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK, S_PAUSE} state_t;

  state_t         state;
  logic [SW-1:0]  skip_cnt;
  logic           ev_vld;
  logic [9:0]     ev_word;

  logic [9:0]     mem [DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic           pop, wr_ok;
  logic [9:0]     head;

  // Decoder: advances on each received byte, emits a registered event word.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state    <= S_IDLE;
      skip_cnt <= '0;
      ev_vld   <= 1'b0;
      ev_word  <= '0;
    end else begin
      ev_vld <= 1'b0;
      if (rx_valid) begin
        case (state)
          S_IDLE: begin
            case (rx_data)
              8'hE0: state <= S_EXT;
              8'hF0: state <= S_BRK;
              8'hE1: begin
                state    <= S_PAUSE;
                skip_cnt <= SW'(PAUSE_LEN);
              end
              // BAT result, ack, echo, resend, error codes: not key actions
              8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: ;
              default: begin
                ev_vld  <= 1'b1;
                ev_word <= {2'b00, rx_data};
              end
            endcase
          end
          S_EXT: begin
            case (rx_data)
              8'hF0:        state <= S_EXT_BRK;
              8'hE0, 8'hE1: ;
              default: begin
                ev_vld  <= 1'b1;
                ev_word <= {2'b10, rx_data};
                state   <= S_IDLE;
              end
            endcase
          end
          S_BRK: begin
            // A second prefix right after F0 is malformed; drop it and resync.
            if (rx_data != 8'hF0 && rx_data != 8'hE0) begin
              ev_vld  <= 1'b1;
              ev_word <= {2'b01, rx_data};
            end
            state <= S_IDLE;
          end
          S_EXT_BRK: begin
            ev_vld  <= 1'b1;
            ev_word <= {2'b11, rx_data};
            state   <= S_IDLE;
          end
          S_PAUSE: begin
            // Pause has no break code; report the whole sequence as one E1 event.
            skip_cnt <= skip_cnt - SW'(1);
            if (skip_cnt <= SW'(1)) begin
              ev_vld  <= 1'b1;
              ev_word <= {2'b00, 8'hE1};
              state   <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));
  assign pop   = rd_en && !empty;
  // When full, a push is accepted only if a pop frees a slot in the same cycle.
  assign wr_ok = ev_vld && (!full || pop);

  // Event storage; pointers alone define validity, so no reset is needed here.
  always_ff @(posedge CLK) begin
    if (RST_N && wr_ok) mem[wr_ptr] <= ev_word;
  end

  // Pointers, occupancy and sticky overflow.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
      case ({wr_ok, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
      // A drop in the same cycle as a clear wins, so no lost event goes unreported.
      if (ev_vld && !wr_ok) overflow <= 1'b1;
      else if (ovf_clr)     overflow <= 1'b0;
    end
  end

  assign head    = empty ? 10'h0 : mem[rd_ptr];
  assign rd_data = {!empty, overflow, 9'b0, count, 6'b0, head};

endmodule

// File: tb/tb_ps2_key_event_fifo.sv
// Scoreboarded bench for ps2_key_event_fifo: directed byte sequences push
// expected event words; a monitor pops and compares whatever the FIFO presents.
module tb_ps2_key_event_fifo;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rd_en;
  logic        ovf_clr;
  logic [31:0] rd_data;
  logic        empty, full, overflow;

  logic        rd_man, rd_mon, mon_en;
  logic [9:0]  exp_q[$];
  int          checks = 0;
  int          failures = 0;

  assign rd_en = rd_man | rd_mon;

  ps2_key_event_fifo #(.DEPTH(16), .CNT_W(5), .PAUSE_LEN(7)) dut (
    .CLK(CLK), .RST_N(RST_N), .rx_data(rx_data), .rx_valid(rx_valid),
    .rd_en(rd_en), .ovf_clr(ovf_clr), .rd_data(rd_data),
    .empty(empty), .full(full), .overflow(overflow)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge CLK); #1;
    rx_data = b; rx_valid = 1'b1;
    @(posedge CLK); #1;
    rx_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic pop_once();
    rd_man = 1'b1;
    @(posedge CLK); #1;
    rd_man = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !empty) && n < 200) begin
      @(posedge CLK); n++;
    end
    #1;
    checks++;
    if (n >= 200) begin
      failures++;
      $display("FAIL %s: drain timeout, %0d events still expected", name, exp_q.size());
    end
  endtask

  // Monitor: compare the head entry against the scoreboard, then pop it.
  initial begin
    rd_mon = 1'b0;
    forever begin
      @(negedge CLK);
      if (mon_en && !empty) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_event: got %h expected none", rd_data[9:0]);
        end else begin
          logic [9:0] e;
          e = exp_q.pop_front();
          if (rd_data[9:0] !== e || rd_data[31] !== 1'b1) begin
            failures++;
            $display("FAIL event: got %h expected %h", rd_data, {1'b1, 21'h0, e});
          end
        end
        rd_mon = 1'b1;
        @(posedge CLK); #1;
        rd_mon = 1'b0;
      end
    end
  end

  initial begin
    RST_N = 1'b0; rx_data = '0; rx_valid = 1'b0; rd_man = 1'b0;
    ovf_clr = 1'b0; mon_en = 1'b0;
    cycles(3);
    RST_N = 1'b1;
    cycles(1);
    check("reset_rd_data", rd_data, 32'h0);
    check("reset_flags", {29'h0, empty, full, overflow}, 32'h4);

    // Latency: nothing visible right after the byte, visible one cycle later.
    send(8'h1C);
    check("latency_still_empty", {31'h0, empty}, 32'h1);
    cycles(1);
    check("first_event", rd_data, 32'h8001_001C);
    pop_once();
    check("after_pop", rd_data, 32'h0);

    // Decode patterns through the scoreboard.
    mon_en = 1'b1;
    exp_q.push_back(10'h11C); send(8'hF0); send(8'h1C);
    exp_q.push_back(10'h375); send(8'hE0); send(8'hF0); send(8'h75);
    exp_q.push_back(10'h275); send(8'hE0); send(8'h75);
    wait_drain("decode");

    // Pause sequence collapses to one E1 event, then decoding resumes.
    exp_q.push_back(10'h0E1); exp_q.push_back(10'h01C);
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    send(8'h1C);
    wait_drain("pause");
    mon_en = 1'b0;
    cycles(2);

    // Discarded control bytes leave exactly one event.
    send(8'hAA); send(8'hFA); send(8'h1C);
    cycles(2);
    check("discard_count", rd_data, 32'h8001_001C);
    pop_once();
    check("discard_empty", {31'h0, empty}, 32'h1);

    // Fill past capacity: 16 accepted, 17th dropped.
    for (int i = 0; i < 17; i++) send(8'h10 + 8'(i));
    cycles(2);
    check("full_word", rd_data, 32'hC010_0010);
    check("full_flags", {29'h0, empty, full, overflow}, 32'h3);
    ovf_clr = 1'b1;
    cycles(1);
    ovf_clr = 1'b0;
    check("ovf_cleared", rd_data, 32'h8010_0010);

    // Pop and push land on the same edge while full.
    @(posedge CLK); #1;
    rx_data = 8'h30; rx_valid = 1'b1;
    @(posedge CLK); #1;
    rx_valid = 1'b0; rd_man = 1'b1;
    @(posedge CLK); #1;
    rd_man = 1'b0;
    check("popush_word", rd_data, 32'h8010_0011);
    check("popush_flags", {29'h0, empty, full, overflow}, 32'h2);
    for (int i = 1; i < 16; i++) exp_q.push_back(10'h010 + 10'(i));
    exp_q.push_back(10'h030);
    mon_en = 1'b1;
    wait_drain("tail_order");
    mon_en = 1'b0;

    // Reset mid-sequence drops the pending break prefix.
    send(8'hF0);
    @(posedge CLK); #1;
    RST_N = 1'b0;
    @(posedge CLK); #1;
    RST_N = 1'b1;
    check("mid_reset_empty", rd_data, 32'h0);
    send(8'h1C);
    cycles(1);
    check("mid_reset_event", rd_data, 32'h8001_001C);
    pop_once();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
